vga_frame_monitor: RTL and testbench
====================================

Name: vga_frame_monitor

Overview:
- Receive-side counterpart of the VGA output path: samples hSync, vSync and 12-bit rgb at the display controller's pixel rate, recovers pixel/line coordinates, and checks sync timing and blanking against 640x480@60 parameters.
- Produces a lock flag, recovered coordinates, a per-frame rgb checksum and an error count.
- Used for on-board self-check and as the scoreboard front end in the top-level bench. Sits beside the VGA pins, fed by the same 100 MHz clock.

Parameters:
- H_TOTAL, 800, pixels per line
- H_SYNC, 96, hSync low width in pixels
- H_ACT_START, 144, first active pixel (hc)
- H_ACTIVE, 640, active pixels per line
- V_TOTAL, 525, lines per frame
- V_ACT_START, 35, first active line (vc)
- V_ACTIVE, 480, active lines per frame

Ports:
- Clk  in  1  100 MHz system clock
- Reset_n  in  1  asynchronous, active-low reset
- pix_en  in  1  pixel strobe (clk25 sampled on Clk); all sampling is gated by it
- hSync  in  1  horizontal sync, active low
- vSync  in  1  vertical sync, active low
- rgb  in  12  {R,G,B} pixel value
- locked  out  1  timing verified for at least one full frame
- hc_out  out  10  recovered pixel index, 0 at hSync falling edge
- vc_out  out  10  recovered line index, 0 on first line of vSync low
- active  out  1  locked and (hc_out, vc_out) inside the active window
- frame_done  out  1  one-Clk pulse at each valid frame boundary
- frame_sum  out  16  checksum of the completed frame
- err_count  out  8  saturating error count

Behaviour:
- Reset (async, Reset_n=0): every output and internal register is 0; state = SEARCH. Release takes effect on the next Clk edge.
- Only cycles with pix_en=1 advance anything. With pix_en=0 all state holds; frame_done is forced to 0.
- Registered previous hSync/vSync are reset to 1.
- h_fall = prev hSync 1 and current hSync 0. On h_fall: hc <= 0. Otherwise hc <= hc+1, saturating at 1023.
- On h rise (0 to 1), hc+1 must equal H_SYNC; otherwise sync_err.
- On h_fall, hc+1 must equal H_TOTAL; otherwise line_err. This check is skipped in SEARCH.
- frame_start = h_fall with vSync=0 while vSync was 1 at the previous h_fall. It sets vc <= 0. Any other h_fall sets vc <= vc+1, saturating at 1023.
- On frame_start, vc+1 must equal V_TOTAL; otherwise frame_err. This check is skipped in SEARCH.
- blank_err: rgb != 0 on a sampled pixel outside the active window while not in SEARCH.
- in_window = hc in [H_ACT_START, H_ACT_START+H_ACTIVE) and vc in [V_ACT_START, V_ACT_START+V_ACTIVE).
- Checksum: acc <= (acc + rgb) mod 2^16 on every in_window sample. acc clears at frame_start.
- State machine (err = any error class on the current sample):
  - SEARCH: frame_start -> ALIGN.
  - ALIGN: err -> SEARCH. frame_start with a clean frame -> LOCKED, frame_done=1, frame_sum <= acc.
  - LOCKED: err -> SEARCH, locked drops on the same edge. frame_start -> stay LOCKED, frame_done=1, frame_sum <= acc.
- An error on the same sample as frame_start takes priority: go to SEARCH with no frame_done and no frame_sum update.
- err_count increments by 1 per sample carrying any error (multiple classes on one sample count once). It saturates at 255 and clears only on reset.
- Outputs are registered.
  - locked = (state == LOCKED).
  - hc_out and vc_out track the internal counters with 1 Clk latency after the sampled pix_en edge.
  - active = locked and in_window.
- frame_sum holds its value until the next valid frame_done.

Test Plan:
- Nominal timing, rgb=0x001 in window, 0 elsewhere, 3 frames:
  - locked rises at the 2nd frame_start.
  - frame_done at the 2nd and 3rd frame_starts.
  - frame_sum = 0xB000 (307200 mod 65536); err_count = 0.
- Locked stream, one line of 799 pixels in frame 3:
  - line_err: err_count = 1, locked = 0 the cycle after.
  - No frame_done at the next frame_start; locked again after two further clean frame_starts.
- hSync low width 95 on one line -> sync_err, err_count +1, lock lost. Width 96 on all lines -> no error.
- rgb=0xF00 at hc=10, vc=100 while locked -> blank_err, err_count +1. The same value at hc=200 -> no error; frame_sum includes 0xF00.
- 300 consecutive erroneous samples -> err_count saturates at 255.
- Reset_n pulsed low mid-frame while locked -> all outputs 0 immediately (asynchronous).
- pix_en held 0 for 50 Clk -> hc_out, vc_out and state frozen, no frame_done.

Source files
------------

// File: rtl/vga_frame_monitor.sv
// VGA receive-side frame monitor: recovers pixel/line position from sync,
// checks sync timing and blanking, and checksums every active frame.
module vga_frame_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_ACT_START = 144,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_ACT_START = 35,
  parameter int V_ACTIVE    = 480
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        pix_en,
  input  logic        hSync,
  input  logic        vSync,
  input  logic [11:0] rgb,
  output logic        locked,
  output logic [9:0]  hc_out,
  output logic [9:0]  vc_out,
  output logic        active,
  output logic        frame_done,
  output logic [15:0] frame_sum,
  output logic [7:0]  err_count
);

  localparam logic [10:0] HT = 11'(H_TOTAL);
  localparam logic [10:0] HS = 11'(H_SYNC);
  localparam logic [10:0] VT = 11'(V_TOTAL);
  localparam logic [9:0] H_LO = 10'(H_ACT_START);
  localparam logic [9:0] H_HI = 10'(H_ACT_START + H_ACTIVE);
  localparam logic [9:0] V_LO = 10'(V_ACT_START);
  localparam logic [9:0] V_HI = 10'(V_ACT_START + V_ACTIVE);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_ALIGN,
    ST_LOCKED
  } state_e;

  function automatic logic in_win(
    logic [9:0] h,
    logic [9:0] v
  );
    return (h >= H_LO) && (h < H_HI) &&
           (v >= V_LO) && (v < V_HI);
  endfunction

  state_e      state_q, state_d;
  logic        hs_q, vs_hf_q, vs_hf_d;
  logic [9:0]  hc_q, hc_d, vc_q, vc_d;
  logic [15:0] acc_q, acc_d, sum_q, sum_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        fd_q, locked_q, active_q;

  logic [10:0] hc_inc, vc_inc;
  logic        h_fall, h_rise, fstart, searching;
  logic        win_now, sync_err, line_err;
  logic        frame_err, blank_err, err, commit;

  always_comb begin
    hc_inc    = {1'b0, hc_q} + 11'd1;
    vc_inc    = {1'b0, vc_q} + 11'd1;
    h_fall    = hs_q & ~hSync;
    h_rise    = ~hs_q & hSync;
    fstart    = h_fall & ~vSync & vs_hf_q;
    searching = (state_q == ST_SEARCH);
    win_now   = in_win(hc_q, vc_q);
    sync_err  = h_rise & (hc_inc != HS);
    line_err  = h_fall & ~searching & (hc_inc != HT);
    frame_err = fstart & ~searching & (vc_inc != VT);
    blank_err = ~searching & ~win_now & (rgb != 12'd0);
    err       = sync_err | line_err | frame_err | blank_err;
    commit    = fstart & ~err & ~searching;
  end

  // an error on a frame-start sample wins over the frame boundary
  always_comb begin
    state_d = state_q;
    if (err) begin
      state_d = ST_SEARCH;
    end else if (fstart) begin
      unique case (state_q)
        ST_SEARCH: state_d = ST_ALIGN;
        ST_ALIGN:  state_d = ST_LOCKED;
        ST_LOCKED: state_d = ST_LOCKED;
        default:   state_d = ST_SEARCH;
      endcase
    end
  end

  always_comb begin
    hc_d    = h_fall ? 10'd0 :
              (&hc_q) ? hc_q : hc_q + 10'd1;
    vc_d    = vc_q;
    if (fstart)
      vc_d = 10'd0;
    else if (h_fall && !(&vc_q))
      vc_d = vc_q + 10'd1;
    vs_hf_d = h_fall ? vSync : vs_hf_q;
    acc_d   = acc_q;
    if (fstart)
      acc_d = 16'd0;
    else if (win_now)
      acc_d = acc_q + {4'd0, rgb};
    sum_d   = commit ? acc_q : sum_q;
    cnt_d   = (err && !(&cnt_q)) ?
              cnt_q + 8'd1 : cnt_q;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= ST_SEARCH;
      hs_q     <= 1'b1;
      vs_hf_q  <= 1'b1;
      hc_q     <= 10'd0;
      vc_q     <= 10'd0;
      acc_q    <= 16'd0;
      sum_q    <= 16'd0;
      cnt_q    <= 8'd0;
      fd_q     <= 1'b0;
      locked_q <= 1'b0;
      active_q <= 1'b0;
    end else begin
      fd_q <= pix_en & commit;
      if (pix_en) begin
        state_q  <= state_d;
        hs_q     <= hSync;
        vs_hf_q  <= vs_hf_d;
        hc_q     <= hc_d;
        vc_q     <= vc_d;
        acc_q    <= acc_d;
        sum_q    <= sum_d;
        cnt_q    <= cnt_d;
        locked_q <= (state_d == ST_LOCKED);
        active_q <= (state_d == ST_LOCKED) &
                    in_win(hc_d, vc_d);
      end
    end
  end

  assign locked     = locked_q;
  assign hc_out     = hc_q;
  assign vc_out     = vc_q;
  assign active     = active_q;
  assign frame_done = fd_q;
  assign frame_sum  = sum_q;
  assign err_count  = cnt_q;

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Bench for vga_frame_monitor: scaled-down raster, randomized pixels
// and strobe gaps, pixel-level reference model feeding a scoreboard.
module tb_vga_frame_monitor;

  localparam int HT  = 40;
  localparam int HS  = 6;
  localparam int HAS = 10;
  localparam int HA  = 24;
  localparam int VT  = 20;
  localparam int VAS = 4;
  localparam int VA  = 12;

  bit          Clk;
  logic        Reset_n, pix_en, hSync, vSync;
  logic [11:0] rgb;
  logic        locked, active, frame_done;
  logic [9:0]  hc_out, vc_out;
  logic [15:0] frame_sum;
  logic [7:0]  err_count;

  vga_frame_monitor #(
    .H_TOTAL(HT), .H_SYNC(HS),
    .H_ACT_START(HAS), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_ACT_START(VAS),
    .V_ACTIVE(VA)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .pix_en(pix_en), .hSync(hSync),
    .vSync(vSync), .rgb(rgb),
    .locked(locked), .hc_out(hc_out),
    .vc_out(vc_out), .active(active),
    .frame_done(frame_done),
    .frame_sum(frame_sum),
    .err_count(err_count)
  );

  initial begin
    Clk = 0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    bit lk; int hc; int vc; bit act;
    bit fd; int sum; int cnt;
  } exp_t;

  typedef struct {
    string nm; int sig; int val;
  } req_t;

  exp_t sbq[$];
  req_t rq[$];
  int   tests = 0;
  int   fails = 0;
  bit   took;
  int   last_hc, last_vc;

  // reference model: state 0 search, 1 align, 2 locked
  int m_st, m_cnt, m_acc, m_sum, m_vc, m_prev_len;

  int k_bad_line, k_bad_len, k_sync_line, k_sync_w;
  int k_inj_l, k_inj_p, k_gap_l, k_gap_p, k_mode;
  logic [11:0] k_inj_v;

  function automatic bit win(int h, int v);
    return h >= HAS && h < HAS + HA &&
           v >= VAS && v < VAS + VA;
  endfunction

  function automatic int sigval(int s);
    case (s)
      0:       return int'(locked);
      1:       return int'(err_count);
      2:       return int'(frame_sum);
      default: return sbq.size();
    endcase
  endfunction

  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_acc = 0;
    m_sum = 0; m_vc = 0; m_prev_len = 1;
  endtask

  task automatic clear_knobs();
    k_bad_line = -1; k_bad_len = HT;
    k_sync_line = -1; k_sync_w = HS;
    k_inj_l = -1; k_inj_p = -1;
    k_inj_v = 12'h000;
    k_gap_l = -1; k_gap_p = -1;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge Clk);
      pix_en = 0;
      hSync  = 1'($urandom);
      vSync  = 1'($urandom);
      rgb    = 12'($urandom);
    end
  endtask

  task automatic settle();
    @(negedge Clk);
    pix_en = 0;
  endtask

  task automatic expect_sig(string nm, int sig, int val);
    rq.push_back('{nm, sig, val});
  endtask

  task automatic send(int p, int w, bit vlow, bit fs,
                      bit use_inj);
    bit fall, rise, srch, e, fd, wb;
    int hcb;
    logic [11:0] px;
    if ($urandom_range(7) == 0)
      idle(1 + $urandom_range(2));
    fall = (p == 0);
    rise = (p == w);
    // counter value in effect while this pixel is sampled
    hcb  = fall ? m_prev_len - 1 : p - 1;
    wb   = win(hcb, m_vc);
    if (use_inj)     px = k_inj_v;
    else if (wb)     px = (k_mode == 0) ? 12'h001
                                        : 12'($urandom);
    else             px = 12'h000;
    srch = (m_st == 0);
    e = (rise && w != HS) ||
        (!srch && ((fall && m_prev_len != HT) ||
                   (fs && m_vc + 1 != VT) ||
                   (px != 0 && !wb)));
    fd = 0;
    if (e) m_st = 0;
    else if (fs) begin
      if (!srch) begin fd = 1; m_sum = m_acc; end
      m_st = srch ? 1 : 2;
    end
    if (fs)      m_acc = 0;
    else if (wb) m_acc = (m_acc + int'(px)) % 65536;
    if (e && m_cnt < 255) m_cnt++;
    if (fs)                     m_vc = 0;
    else if (fall && m_vc < 1023) m_vc++;
    sbq.push_back('{m_st == 2, p, m_vc,
                    m_st == 2 && win(p, m_vc),
                    fd, m_sum, m_cnt});
    @(negedge Clk);
    pix_en = 1;
    hSync  = (p >= w);
    vSync  = !vlow;
    rgb    = px;
  endtask

  task automatic send_line(int len, int w, bit vlow,
                           bit fs, int inj_p, int gap_p);
    for (int p = 0; p < len; p++) begin
      if (p == gap_p) idle(50);
      send(p, w, vlow, fs && p == 0, p == inj_p);
    end
    m_prev_len = len;
  endtask

  task automatic send_frame(int nlines);
    for (int l = 0; l < nlines; l++)
      send_line(l == k_bad_line ? k_bad_len : HT,
                l == k_sync_line ? k_sync_w : HS,
                l < 2, l == 0,
                l == k_inj_l ? k_inj_p : -1,
                l == k_gap_l ? k_gap_p : -1);
  endtask

  task automatic do_reset();
    settle();
    #3 Reset_n = 0;
    repeat (3) @(negedge Clk);
    #3 Reset_n = 1;
    model_reset();
  endtask

  always @(posedge Clk) took <= pix_en && Reset_n;

  always begin
    exp_t e;
    req_t r;
    @(negedge Clk or negedge Reset_n);
    #1;
    if (!Reset_n) begin
      chk("rst_locked", int'(locked), 0);
      chk("rst_hc", int'(hc_out), 0);
      chk("rst_vc", int'(vc_out), 0);
      chk("rst_active", int'(active), 0);
      chk("rst_frame_done", int'(frame_done), 0);
      chk("rst_frame_sum", int'(frame_sum), 0);
      chk("rst_err_count", int'(err_count), 0);
      last_hc = 0;
      last_vc = 0;
    end else if (took) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_underflow: got empty queue, expected entry");
      end else begin
        e = sbq.pop_front();
        chk("locked", int'(locked), int'(e.lk));
        chk("hc_out", int'(hc_out), e.hc);
        chk("vc_out", int'(vc_out), e.vc);
        chk("active", int'(active), int'(e.act));
        chk("frame_done", int'(frame_done), int'(e.fd));
        chk("frame_sum", int'(frame_sum), e.sum);
        chk("err_count", int'(err_count), e.cnt);
        last_hc = e.hc;
        last_vc = e.vc;
      end
    end else begin
      chk("idle_frame_done", int'(frame_done), 0);
      chk("idle_hc", int'(hc_out), last_hc);
      chk("idle_vc", int'(vc_out), last_vc);
    end
    while (rq.size() > 0) begin
      r = rq.pop_front();
      chk(r.nm, sigval(r.sig), r.val);
    end
  end

  initial begin
    Reset_n = 1; pix_en = 0;
    hSync = 1; vSync = 1; rgb = 0;
    k_mode = 0;
    clear_knobs();
    model_reset();
    #2 Reset_n = 0;
    repeat (3) @(negedge Clk);
    #3 Reset_n = 1;

    repeat (4) send_frame(VT);
    settle();
    expect_sig("nom_locked", 0, 1);
    expect_sig("nom_sum", 2, HA * VA);
    expect_sig("nom_errs", 1, 0);

    k_bad_line = 7; k_bad_len = HT - 1;
    send_frame(VT);
    settle();
    expect_sig("line_err_cnt", 1, 1);
    expect_sig("line_err_unlock", 0, 0);
    clear_knobs();
    repeat (2) send_frame(VT);
    settle();
    expect_sig("line_relock", 0, 1);

    k_mode = 1;
    k_sync_line = 3; k_sync_w = HS - 1;
    send_frame(VT);
    settle();
    expect_sig("sync_err_cnt", 1, 2);
    expect_sig("sync_unlock", 0, 0);
    clear_knobs();
    repeat (2) send_frame(VT);
    settle();
    expect_sig("sync_relock", 0, 1);

    k_inj_l = VAS + 2; k_inj_p = 3;
    k_inj_v = 12'hF00;
    send_frame(VT);
    settle();
    expect_sig("blank_err_cnt", 1, 3);
    expect_sig("blank_unlock", 0, 0);
    k_inj_l = -1;
    send_frame(VT);
    k_inj_l = VAS + 3; k_inj_p = HAS + 6;
    send_frame(VT);
    k_inj_l = -1;
    send_frame(VT);
    settle();
    expect_sig("inwin_f00_cnt", 1, 3);
    expect_sig("inwin_f00_lock", 0, 1);

    k_gap_l = 5; k_gap_p = 20;
    send_frame(VT);
    clear_knobs();
    settle();
    expect_sig("gap_lock", 0, 1);
    expect_sig("gap_cnt", 1, 3);

    send_frame(8);
    send_line(15, HS, 0, 0, -1, -1);
    do_reset();

    repeat (300) send_line(8, 2, 0, 0, -1, -1);
    settle();
    expect_sig("sat_cnt", 1, 255);
    expect_sig("sat_unlock", 0, 0);

    k_mode = 0;
    repeat (3) send_frame(VT);
    settle();
    expect_sig("final_lock", 0, 1);
    expect_sig("final_cnt", 1, 255);
    expect_sig("final_sum", 2, HA * VA);

    repeat (3) @(negedge Clk);
    expect_sig("scoreboard_drain", 5, 0);
    repeat (2) @(negedge Clk);
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
